// File: rtl/light_package.sv
// light_package: light colour type, queue defaults and lane indices
package light_package;
   typedef enum logic [1:0] {red, yellow, green} colors;
   localparam int QDEPTH_DEF  = 15;
   localparam int HEADWAY_DEF = 2;
   localparam int LANE_ES     = 0;
   localparam int LANE_EL     = 1;
   localparam int LANE_WS     = 2;
   localparam int LANE_WL     = 3;
   localparam int LANE_NS     = 4;
endpackage

// File: rtl/traffic_queue_model_if.sv
// traffic_queue_model_if: arrivals, lights and queue status of the intersection
interface traffic_queue_model_if;
   import light_package::*;
   logic [4:0]      arrive;
   colors           e_str_light, e_left_light, w_str_light, w_left_light, ns_light;
   logic            e_str_sensor, e_left_sensor, w_str_sensor, w_left_sensor, ns_sensor;
   logic [4:0][3:0] q_count;
   logic [4:0]      overflow;
   logic            conflict_err, seq_err;
   logic [7:0]      served_cnt;
   modport master (
      output arrive, e_str_light, e_left_light, w_str_light, w_left_light, ns_light,
      input  e_str_sensor, e_left_sensor, w_str_sensor, w_left_sensor, ns_sensor,
      input  q_count, overflow, conflict_err, seq_err, served_cnt
   );
   modport slave (
      input  arrive, e_str_light, e_left_light, w_str_light, w_left_light, ns_light,
      output e_str_sensor, e_left_sensor, w_str_sensor, w_left_sensor, ns_sensor,
      output q_count, overflow, conflict_err, seq_err, served_cnt
   );
endinterface

// File: rtl/traffic_queue_model_lane.sv
// traffic_lane: one lane queue with departure headway and colour history
module traffic_lane import light_package::*; #(
   parameter int QDEPTH  = QDEPTH_DEF,
   parameter int HEADWAY = HEADWAY_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       arrive,
   input  colors      light,
   output logic [3:0] count,
   output logic       overflow,
   output logic       depart,
   output logic       seq_bad
);
   logic [3:0] headway;
   colors      last;
   logic       full;
   assign full    = count == 4'(QDEPTH);
   assign depart  = light == green && |count && headway == 4'd0;
   assign seq_bad = last == green && light == red;
   // queue occupancy, departure spacing, previous colour and sticky drop flag
   always_ff @(posedge clk)
      if (reset) begin
         count    <= 4'd0;
         headway  <= 4'd0;
         last     <= red;
         overflow <= 1'b0;
      end else begin
         count    <= arrive && !depart && !full ? count + 4'd1 :
                     depart && !arrive ? count - 4'd1 : count;
         headway  <= depart ? 4'(HEADWAY - 1) : light != green ? 4'd0 :
                     headway != 4'd0 ? headway - 4'd1 : 4'd0;
         last     <= light;
         overflow <= overflow | (arrive && !depart && full);
      end
endmodule

// File: rtl/traffic_queue_model.sv
// traffic_queue_model: five lane queues plus light conflict/sequence checks
module traffic_queue_model import light_package::*; #(
   parameter int QDEPTH  = QDEPTH_DEF,
   parameter int HEADWAY = HEADWAY_DEF
) (
   input logic                  clk,
   input logic                  reset,
   traffic_queue_model_if.slave bus
);
   colors      light [5];
   logic [4:0] depart, seq_bad, nr;
   logic       conflict;
   assign light = '{bus.e_str_light, bus.e_left_light, bus.w_str_light, bus.w_left_light, bus.ns_light};
   for (genvar i = 0; i < 5; i++) begin : g_lane
      assign nr[i] = light[i] != red;
      traffic_lane #(.QDEPTH(QDEPTH), .HEADWAY(HEADWAY)) u_lane (
         .clk(clk), .reset(reset), .arrive(bus.arrive[i]), .light(light[i]),
         .count(bus.q_count[i]), .overflow(bus.overflow[i]),
         .depart(depart[i]), .seq_bad(seq_bad[i])
      );
   end
   assign bus.e_str_sensor  = |bus.q_count[LANE_ES];
   assign bus.e_left_sensor = |bus.q_count[LANE_EL];
   assign bus.w_str_sensor  = |bus.q_count[LANE_WS];
   assign bus.w_left_sensor = |bus.q_count[LANE_WL];
   assign bus.ns_sensor     = |bus.q_count[LANE_NS];
   assign conflict = (nr[LANE_EL] && (nr[LANE_WS] || nr[LANE_NS])) ||
                     (nr[LANE_WL] && (nr[LANE_ES] || nr[LANE_NS])) ||
                     (nr[LANE_NS] && (nr[LANE_ES] || nr[LANE_WS]));
   // sticky error flags and running departure total
   always_ff @(posedge clk)
      if (reset) begin
         bus.conflict_err <= 1'b0;
         bus.seq_err      <= 1'b0;
         bus.served_cnt   <= 8'd0;
      end else begin
         bus.conflict_err <= bus.conflict_err | conflict;
         bus.seq_err      <= bus.seq_err | (|seq_bad);
         bus.served_cnt   <= bus.served_cnt + 8'($countones(depart));
      end
endmodule

// File: doc/traffic_queue_model.md
TRAFFIC_QUEUE_MODEL -- requirements
Module: traffic_queue_model

Interface
REQ-001 Parameter QDEPTH, default 15, maximum cars held per lane queue (4-bit counter).
REQ-002 Parameter HEADWAY, default 2, minimum green cycles between successive departures from one lane.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 arrive  input  5  one-cycle car-arrival pulses; bit index 0=e_str, 1=e_left, 2=w_str, 3=w_left, 4=ns.
REQ-006 e_str_light, e_left_light, w_str_light, w_left_light, ns_light  input  2 each  light colour of type colors (red, yellow, green).
REQ-007 e_str_sensor, e_left_sensor, w_str_sensor, w_left_sensor, ns_sensor  output  1 each  lane occupied (queue count nonzero).
REQ-008 q_count  output  5x4  current queue count per lane, same bit index as arrive.
REQ-009 overflow  output  5  sticky per-lane flag: arrival dropped at full queue.
REQ-010 conflict_err  output  1  sticky flag: illegal simultaneous non-red lights seen.
REQ-011 seq_err  output  1  sticky flag: some light went green directly to red.
REQ-012 served_cnt  output  8  total departures across all lanes, modulo 256.

Function
REQ-013 Each lane SHALL hold count (0..QDEPTH), headway down-counter, and last-colour register.
REQ-014 Departure occurs in a cycle where the lane light is green, count>0 and headway=0; the light is sampled in that cycle and count decrements at the next edge.
REQ-015 On departure, headway SHALL load HEADWAY-1; it decrements each green cycle while nonzero; it clears to 0 in any cycle the light is not green.
REQ-016 Yellow and red SHALL never permit a departure.
REQ-017 Arrival increments count at the next edge when count<QDEPTH.
REQ-018 Arrival with count=QDEPTH and no departure: count unchanged; the lane overflow bit is set.
REQ-019 Arrival and departure in the same cycle: count unchanged, no overflow, served_cnt still increments.
REQ-020 Sensor outputs SHALL be a combinational decode of registered count (count!=0); no extra latency.
REQ-021 served_cnt SHALL add the number of departures in the cycle (0..5) and wrap from 255.
REQ-022 conflict_err SHALL be set at the edge after any cycle where e_left non-red with (w_str or ns non-red), w_left non-red with (e_str or ns non-red), or ns non-red with (e_str or w_str non-red).
REQ-023 seq_err SHALL be set when a lane's last colour is green and current colour is red.
REQ-024 Sticky flags SHALL clear only on reset.

Reset
REQ-025 While reset is high at a clock edge: all counts=0, headways=0, last colours=red, overflow=0, conflict_err=0, seq_err=0, served_cnt=0; all sensors therefore 0.
REQ-026 reset SHALL override arrivals and departures in the same cycle; mid-queue reset discards all cars.
REQ-027 Lights SHALL be sampled normally from the first cycle after reset deasserts.

Structure
REQ-028 Type colors remains in light_package; add QDEPTH/HEADWAY defaults and lane index constants (LANE_ES..LANE_NS) there.
REQ-029 One sub-module traffic_lane (count, headway, last colour, overflow, depart output) SHALL be instantiated five times; conflict checking and served_cnt live at top level.

Verification
REQ-030 Reset, 3 arrive[1] pulses, e_left_light red -> q_count[1]=3, e_left_sensor=1, served_cnt=0.
REQ-031 Then e_left_light green 6 cycles -> departures on green cycles 1,3,5; q_count[1]=0 after cycle 5; served_cnt=3.
REQ-032 16 arrive[4] pulses with ns_light red -> q_count[4]=15, overflow[4]=1; next cycle arrival plus green departure -> count 15 unchanged.
REQ-033 e_left_light green with ns_light yellow for one cycle -> conflict_err=1 next edge, stays 1 until reset.
REQ-034 w_str_light green then red next cycle -> seq_err=1; green->yellow->red -> seq_err stays 0.
REQ-035 Assert reset with q_count[0]=5 and all flags set -> all outputs 0 the following cycle.
